exc_commit: RTL and testbench

Exception and return commit unit at the writeback boundary of the five-stage LoongArch core. It arbitrates the writeback instruction's raw exception flags, pending interrupts and `ertn` into a single one-hot exception vector plus an `ertn_flush` pulse for the CSR file. It flushes the pipeline and drives a held redirect request (EENTRY or ERA target) to the fetch stage over a valid/ready handshake. It is the initiator of the CSR exception interface (`exc`, `ertn_flush`, `wb_pc`, `badv_input`) and consumes `has_int`, `csr_eentry_pc` and `csr_eertn_pc`.

---
 rtl/exc_pkg.sv | 24 ++
 rtl/exc_prio_enc.sv | 22 ++
 rtl/exc_commit.sv | 76 +++++++
 tb/tb_exc_commit.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// exc_pkg: shared indices, widths and state encoding for the exception commit unit.
package exc_pkg;
  localparam int EXC_W  = 6;
  localparam int FLAG_W = 5;
  localparam int PC_W   = 32;
  localparam int EXC_SYS  = 0;
  localparam int EXC_INE  = 1;
  localparam int EXC_BRK  = 2;
  localparam int EXC_ALE  = 3;
  localparam int EXC_ADEF = 4;
  localparam int EXC_INT  = 5;
  localparam int FLG_SYS  = 0;
  localparam int FLG_INE  = 1;
  localparam int FLG_BRK  = 2;
  localparam int FLG_ALE  = 3;
  localparam int FLG_ADEF = 4;
  typedef enum logic {IDLE, REDIR} state_e;
  function automatic logic [EXC_W-1:0] exc_bit(input int idx);
    logic [EXC_W-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: resolves interrupt, raw flags and ertn into one one-hot cause or an ertn flush.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic              has_int_i,
  input  logic [FLAG_W-1:0] flags_i,
  input  logic              ertn_i,
  output logic [EXC_W-1:0]  exc_o,
  output logic              ertn_flush_o,
  output logic              is_ex_o
);
  always_comb begin
    exc_o = has_int_i          ? exc_bit(EXC_INT)  :
            flags_i[FLG_ADEF]  ? exc_bit(EXC_ADEF) :
            flags_i[FLG_INE]   ? exc_bit(EXC_INE)  :
            flags_i[FLG_BRK]   ? exc_bit(EXC_BRK)  :
            flags_i[FLG_SYS]   ? exc_bit(EXC_SYS)  :
            flags_i[FLG_ALE]   ? exc_bit(EXC_ALE)  : '0;
    is_ex_o = |exc_o;
    ertn_flush_o = ertn_i & ~is_ex_o;
  end
endmodule

// File: rtl/exc_commit.sv
// exc_commit: writeback exception/ertn commit, pipeline flush and held fetch redirect.
// EXC_ALE_BADV_EN: when defined, ALE reports wb_vaddr on exc_badv.
module exc_commit
  import exc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [PC_W-1:0]   wb_pc,
  input  logic [FLAG_W-1:0] wb_flags,
  input  logic              wb_ertn,
  input  logic [PC_W-1:0]   wb_vaddr,
  input  logic              has_int,
  input  logic [PC_W-1:0]   csr_eentry_pc,
  input  logic [PC_W-1:0]   csr_eertn_pc,
  output logic [EXC_W-1:0]  exc,
  output logic              ertn_flush,
  output logic [PC_W-1:0]   exc_pc,
  output logic [PC_W-1:0]   exc_badv,
  output logic              pipe_flush,
  output logic              wb_commit_ok,
  output logic              redir_valid,
  output logic [PC_W-1:0]   redir_pc,
  input  logic              redir_ready,
  output logic              busy
);
  state_e            state_q, state_d;
  logic [PC_W-1:0]   target_q, target_d;
  logic [EXC_W-1:0]  enc_exc;
  logic              enc_ertn, enc_is_ex, idle, trig;
  logic [PC_W-1:0]   badv_raw;

  exc_prio_enc u_prio (
    .has_int_i    (has_int),
    .flags_i      (wb_flags),
    .ertn_i       (wb_ertn),
    .exc_o        (enc_exc),
    .ertn_flush_o (enc_ertn),
    .is_ex_o      (enc_is_ex)
  );

`ifdef EXC_ALE_BADV_EN
  assign badv_raw = enc_exc[EXC_ADEF] ? wb_pc : enc_exc[EXC_ALE] ? wb_vaddr : '0;
`else
  logic unused_vaddr;
  assign unused_vaddr = ^wb_vaddr;
  assign badv_raw = enc_exc[EXC_ADEF] ? wb_pc : '0;
`endif

  // CSR pulses are combinational and masked during reset so nothing leaks while held.
  always_comb begin
    idle = (state_q == IDLE) & ~reset;
    trig = idle & wb_valid & (has_int | (|wb_flags) | wb_ertn);
    state_d = trig ? REDIR : ((state_q == REDIR) & redir_ready) ? IDLE : state_q;
    target_d = trig ? (enc_is_ex ? csr_eentry_pc : csr_eertn_pc) : target_q;
    exc = trig ? enc_exc : '0;
    ertn_flush = trig & enc_ertn;
    pipe_flush = trig;
    exc_pc = trig ? wb_pc : '0;
    exc_badv = trig ? badv_raw : '0;
    wb_commit_ok = idle & wb_valid & ~trig;
    redir_valid = state_q == REDIR;
    redir_pc = target_q;
    busy = state_q != IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end
endmodule

// File: tb/tb_exc_commit.sv
// tb_exc_commit: table vectors, corner sequences and random stimulus against a behavioural model.
module tb_exc_commit;
  logic        clk = 0, reset = 1;
  logic        wb_valid = 0, wb_ertn = 0, has_int = 0, redir_ready = 0;
  logic [4:0]  wb_flags = 0;
  logic [31:0] wb_pc = 0, wb_vaddr = 0;
  logic [31:0] csr_eentry_pc = 32'h1c008000, csr_eertn_pc = 32'h1c000100;
  logic [5:0]  exc;
  logic        ertn_flush, pipe_flush, wb_commit_ok, redir_valid, busy;
  logic [31:0] exc_pc, exc_badv, redir_pc;
  int checks = 0, errors = 0;
  bit          m_redir = 0;
  logic [31:0] m_tgt = 0;
`ifdef EXC_ALE_BADV_EN
  bit ale_en = 1;
`else
  bit ale_en = 0;
`endif

  exc_commit dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_flags(wb_flags),
    .wb_ertn(wb_ertn), .wb_vaddr(wb_vaddr), .has_int(has_int),
    .csr_eentry_pc(csr_eentry_pc), .csr_eertn_pc(csr_eertn_pc), .exc(exc),
    .ertn_flush(ertn_flush), .exc_pc(exc_pc), .exc_badv(exc_badv), .pipe_flush(pipe_flush),
    .wb_commit_ok(wb_commit_ok), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .redir_ready(redir_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] f, input logic e, input logic i, input logic r);
    wb_valid = v; wb_flags = f; wb_ertn = e; has_int = i; redir_ready = r;
  endtask

  // Causes listed highest priority first, each with its one-hot exc position.
  task automatic model_check(output bit trig, output logic [5:0] e);
    int  pos[6];
    bit  req[6];
    logic [31:0] badv;
    pos = '{5, 4, 1, 2, 0, 3};
    req = '{has_int, wb_flags[4], wb_flags[1], wb_flags[2], wb_flags[0], wb_flags[3]};
    trig = !m_redir && wb_valid && (has_int || wb_flags != 0 || wb_ertn);
    e = 0;
    if (trig)
      for (int i = 0; i < 6; i++)
        if (req[i]) begin e[pos[i]] = 1; break; end
    badv = e[4] ? wb_pc : (e[3] && ale_en) ? wb_vaddr : 32'h0;
    chk("exc", 32'(exc), 32'(e));
    chk("ertn_flush", 32'(ertn_flush), 32'(trig && e == 0));
    chk("pipe_flush", 32'(pipe_flush), 32'(trig));
    chk("exc_pc", exc_pc, trig ? wb_pc : 32'h0);
    chk("exc_badv", exc_badv, badv);
    chk("wb_commit_ok", 32'(wb_commit_ok), 32'(!m_redir && wb_valid && !trig));
    chk("redir_valid", 32'(redir_valid), 32'(m_redir));
    chk("redir_pc", redir_pc, m_tgt);
    chk("busy", 32'(busy), 32'(m_redir));
  endtask

  task automatic cycle();
    bit trig;
    logic [5:0] e;
    #3;
    model_check(trig, e);
    @(posedge clk);
    if (trig) begin
      m_redir = 1;
      m_tgt = (e != 0) ? csr_eentry_pc : csr_eertn_pc;
    end else if (m_redir && redir_ready) m_redir = 0;
    #1;
  endtask

  typedef struct {
    logic v; logic [4:0] f; logic e; logic i;
    logic [5:0] x_exc; logic x_ertn; logic x_flush;
  } vec_t;
  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1, 5'b10010, 0, 0, 6'b010000, 0, 1};
    tbl[1]  = '{1, 5'b00001, 0, 0, 6'b000001, 0, 1};
    tbl[2]  = '{1, 5'b01000, 0, 0, 6'b001000, 0, 1};
    tbl[3]  = '{1, 5'b00100, 0, 0, 6'b000100, 0, 1};
    tbl[4]  = '{1, 5'b01001, 0, 0, 6'b000001, 0, 1};
    tbl[5]  = '{1, 5'b01100, 0, 0, 6'b000100, 0, 1};
    tbl[6]  = '{1, 5'b00000, 1, 0, 6'b000000, 1, 1};
    tbl[7]  = '{1, 5'b00000, 1, 1, 6'b100000, 0, 1};
    tbl[8]  = '{1, 5'b00011, 0, 0, 6'b000010, 0, 1};
    tbl[9]  = '{1, 5'b00110, 0, 0, 6'b000010, 0, 1};
    tbl[10] = '{0, 5'b00000, 0, 1, 6'b000000, 0, 0};
    tbl[11] = '{1, 5'b00000, 0, 0, 6'b000000, 0, 0};
    tbl[12] = '{1, 5'b11111, 1, 0, 6'b010000, 0, 1};
    tbl[13] = '{1, 5'b00101, 1, 0, 6'b000100, 0, 1};

    @(posedge clk); #1;
    chk("rst_exc", 32'(exc), 0);
    chk("rst_redir_valid", 32'(redir_valid), 0);
    chk("rst_redir_pc", redir_pc, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_commit", 32'(wb_commit_ok), 0);
    reset = 0;
    cycle();

    wb_vaddr = 32'h00000003;
    for (int k = 0; k < 14; k++) begin
      wb_pc = 32'h1c000040 + 32'(k * 4);
      drive(tbl[k].v, tbl[k].f, tbl[k].e, tbl[k].i, 0);
      #2;
      chk($sformatf("tbl%0d_exc", k), 32'(exc), 32'(tbl[k].x_exc));
      chk($sformatf("tbl%0d_ertn", k), 32'(ertn_flush), 32'(tbl[k].x_ertn));
      chk($sformatf("tbl%0d_flush", k), 32'(pipe_flush), 32'(tbl[k].x_flush));
      cycle();
      if (tbl[k].x_flush) begin
        drive(0, 0, 0, 0, 1);
        #2;
        chk($sformatf("tbl%0d_redir_pc", k), redir_pc, tbl[k].x_ertn ? 32'h1c000100 : 32'h1c008000);
        cycle();
      end
    end

    // ertn with a stalled redirect; a SYS instruction arriving meanwhile is wrong-path
    wb_pc = 32'h1c000200;
    drive(1, 0, 1, 0, 0);
    #2 chk("ertn_pulse", 32'(ertn_flush), 1);
    cycle();
    for (int k = 0; k < 4; k++) begin
      drive(1, 5'b00001, 0, 0, k == 3);
      #2;
      chk("stall_valid", 32'(redir_valid), 1);
      chk("stall_pc", redir_pc, 32'h1c000100);
      chk("stall_exc", 32'(exc), 0);
      chk("stall_commit", 32'(wb_commit_ok), 0);
      cycle();
    end
    drive(0, 0, 0, 0, 0);
    #2 chk("stall_done_busy", 32'(busy), 0);
    cycle();

    // reset asserted while in REDIR
    drive(1, 5'b10000, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0);
    reset = 1;
    #1;
    chk("arst_redir_valid", 32'(redir_valid), 0);
    chk("arst_redir_pc", redir_pc, 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_flush", 32'(pipe_flush), 0);
    m_redir = 0; m_tgt = 0;
    @(posedge clk); #1;
    reset = 0;
    drive(1, 0, 0, 0, 0);
    #2 chk("post_rst_commit", 32'(wb_commit_ok), 1);
    cycle();

    for (int k = 0; k < 500; k++) begin
      wb_pc = $urandom;
      wb_vaddr = $urandom;
      if ($urandom_range(0, 7) == 0) csr_eentry_pc = $urandom;
      if ($urandom_range(0, 7) == 0) csr_eertn_pc = $urandom;
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 1) == 1);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
